// File: rtl/d_bus_router_if.sv
// Core data-bus and slave-port signals of the data-side bus router.
// The slave modport is the router's view; master is the core plus slave devices.
interface d_bus_router_if #(
    parameter int XLEN     = 32,
    parameter int ADDR_LEN = 16,
    parameter int NSLV     = 4
);
    logic [ADDR_LEN-1:0]  addr;
    logic                 rd_req;
    logic                 wr_req;
    logic [XLEN/8-1:0]    be;
    logic [XLEN-1:0]      wr_data;
    logic                 rd_ready;
    logic                 wr_ready;
    logic [XLEN-1:0]      rd_data;
    logic                 bus_err;

    logic [ADDR_LEN-1:0]  slv_addr;
    logic [XLEN/8-1:0]    slv_be;
    logic [XLEN-1:0]      slv_wr_data;
    logic [NSLV-1:0]      slv_rd_req;
    logic [NSLV-1:0]      slv_wr_req;
    logic [NSLV*XLEN-1:0] slv_rd_data;
    logic [NSLV-1:0]      slv_rd_ready;
    logic [NSLV-1:0]      slv_wr_ready;

    modport master (
        output addr, rd_req, wr_req, be, wr_data,
        output slv_rd_data, slv_rd_ready, slv_wr_ready,
        input  rd_ready, wr_ready, rd_data, bus_err,
        input  slv_addr, slv_be, slv_wr_data, slv_rd_req, slv_wr_req
    );

    modport slave (
        input  addr, rd_req, wr_req, be, wr_data,
        input  slv_rd_data, slv_rd_ready, slv_wr_ready,
        output rd_ready, wr_ready, rd_data, bus_err,
        output slv_addr, slv_be, slv_wr_data, slv_rd_req, slv_wr_req
    );
endinterface

// File: rtl/d_bus_router.sv
// Routes one core data-bus transaction to an address-decoded slave port,
// with lowest-index priority, unmapped-address error and a slave watchdog.
//   state  | meaning
//   IDLE   | waiting for rd_req/wr_req; latches request and decode result
//   ACCESS | request driven to selected slave; watchdog counting
//   DONE   | one-cycle rd_ready/wr_ready pulse with bus_err
module d_bus_router #(
    parameter int                       XLEN     = 32,
    parameter int                       ADDR_LEN = 16,
    parameter int                       NSLV     = 4,
    parameter logic [NSLV*ADDR_LEN-1:0] SLV_BASE = '0,
    parameter logic [NSLV*ADDR_LEN-1:0] SLV_MASK = '0,
    parameter int                       TIMEOUT  = 64
) (
    input logic           clk,
    input logic           rstb,
    d_bus_router_if.slave bus
);
    localparam int SEL_W = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam int BE_W  = XLEN / 8;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t              state;
    state_t              state_nx;

    logic [ADDR_LEN-1:0] off_q;
    logic [BE_W-1:0]     be_q;
    logic [XLEN-1:0]     wdata_q;
    logic [XLEN-1:0]     rdata_q;
    logic [SEL_W-1:0]    sel_q;
    logic                op_wr_q;
    logic                err_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                hit;
    logic [SEL_W-1:0]    hit_idx;
    logic [ADDR_LEN-1:0] hit_mask;
    logic                req;
    logic                sel_rdy;
    logic                tmo;
    logic [XLEN-1:0]     sel_rdata;

    // Walk downwards so the lowest matching index is the one left standing.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_mask = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if ((bus.addr & SLV_MASK[i*ADDR_LEN +: ADDR_LEN]) ==
                (SLV_BASE[i*ADDR_LEN +: ADDR_LEN] & SLV_MASK[i*ADDR_LEN +: ADDR_LEN])) begin
                hit      = 1'b1;
                hit_idx  = SEL_W'(i);
                hit_mask = SLV_MASK[i*ADDR_LEN +: ADDR_LEN];
            end
        end
    end

    assign req       = bus.rd_req | bus.wr_req;
    assign sel_rdy   = op_wr_q ? bus.slv_wr_ready[sel_q] : bus.slv_rd_ready[sel_q];
    assign sel_rdata = bus.slv_rd_data[sel_q*XLEN +: XLEN];
    assign tmo       = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx         = state;
        bus.slv_rd_req   = '0;
        bus.slv_wr_req   = '0;
        bus.rd_ready     = 1'b0;
        bus.wr_ready     = 1'b0;
        bus.bus_err      = 1'b0;
        case (state)
            IDLE: begin
                if (req) state_nx = hit ? ACCESS : DONE;
            end
            ACCESS: begin
                if (op_wr_q) bus.slv_wr_req[sel_q] = 1'b1;
                else         bus.slv_rd_req[sel_q] = 1'b1;
                if (sel_rdy || tmo) state_nx = DONE;
            end
            DONE: begin
                bus.rd_ready = ~op_wr_q;
                bus.wr_ready = op_wr_q;
                bus.bus_err  = err_q;
                state_nx     = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // A ready in the timeout cycle takes precedence over the watchdog.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            off_q   <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            sel_q   <= '0;
            op_wr_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        off_q   <= bus.addr & ~hit_mask;
                        be_q    <= bus.be;
                        wdata_q <= bus.wr_data;
                        op_wr_q <= bus.wr_req;
                        sel_q   <= hit_idx;
                        err_q   <= ~hit;
                        cnt_q   <= '0;
                        if (!hit) rdata_q <= '0;
                    end
                end
                ACCESS: begin
                    if (sel_rdy) begin
                        err_q   <= 1'b0;
                        rdata_q <= op_wr_q ? '0 : sel_rdata;
                    end else if (tmo) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.slv_addr    = off_q;
    assign bus.slv_be      = be_q;
    assign bus.slv_wr_data = wdata_q;
    assign bus.rd_data     = rdata_q;
endmodule
